rx_byte_fifo: RTL and testbench
===============================

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving storage of 2^DEPTH_LOG2 bytes (16).
REQ-002 SHALL have parameter AF_LEVEL, default 12, setting the almost-full threshold in bytes.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 SHALL have port in_vld, input, 1, one-cycle byte strobe from the serial receiver.
REQ-006 SHALL have port in_data, input, 8, received byte, qualified by in_vld.
REQ-007 SHALL have port out_vld, output, 1, head byte available.
REQ-008 SHALL have port out_rdy, input, 1, consumer accepts the head byte.
REQ-009 SHALL have port out_data, output, 8, head byte, valid while out_vld=1.
REQ-010 SHALL have port count, output, DEPTH_LOG2+1, number of stored bytes.
REQ-011 SHALL have port almost_full, output, 1, high when count >= AF_LEVEL.
REQ-012 SHALL have port ovf, output, 1, sticky flag for a dropped byte.
REQ-013 SHALL have port ovf_clr, input, 1, synchronous clear of ovf.
REQ-014 SHALL have port ovf_cnt, output, 8, dropped-byte counter (see Configuration).

Function
REQ-015 SHALL push in_data when in_vld=1 and the FIFO is not full, or is full with a pop in the same cycle.
REQ-016 SHALL pop the head byte when out_vld=1 and out_rdy=1.
REQ-017 SHALL drive out_vld = (count != 0) and out_data = the oldest stored byte; first-word-fall-through.
REQ-018 SHALL give 1-cycle latency: a byte pushed into an empty FIFO at edge N gives out_vld=1 after edge N.
REQ-019 SHALL hold out_data stable while out_vld=1 and out_rdy=0.
REQ-020 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL use DEPTH_LOG2-bit read and write pointers that wrap modulo 2^DEPTH_LOG2.
REQ-022 SHALL define full as count == 2^DEPTH_LOG2 and empty as count == 0.
REQ-023 SHALL ignore out_rdy when empty: no pop, and the pointers do not change.
REQ-024 SHALL treat in_vld=1 when full with no same-cycle pop as a drop: storage is unchanged and ovf is set to 1 on the next edge.
REQ-025 SHALL clear ovf on ovf_clr=1; a drop in the same cycle as ovf_clr takes priority, leaving ovf=1.
REQ-026 SHALL register almost_full, so that it reflects the post-update count in the same cycle count changes.
REQ-027 SHALL accept an in_vld pulse on every cycle; the producer is never back-pressured.

Reset
REQ-028 SHALL, while rst_n=0, force count=0, pointers=0, out_vld=0, almost_full=0, ovf=0 and ovf_cnt=0, asynchronously.
REQ-029 SHALL NOT require storage contents to be reset; out_data is don't-care while out_vld=0.
REQ-030 SHALL discard all stored bytes when reset is asserted mid-operation, and accept a push on the first edge after rst_n rises.

Configuration
REQ-031 SHALL, with macro RX_BYTE_FIFO_OVF_CNT_EN defined, increment ovf_cnt by 1 on each drop, saturate it at 255, and clear it on ovf_clr with the same priority as ovf.
REQ-032 SHALL, without RX_BYTE_FIFO_OVF_CNT_EN, tie ovf_cnt to constant 0 and include no counter logic.

Verification
REQ-033 Reset then push 0x41 with out_rdy=0 -> next cycle out_vld=1, out_data=0x41, count=1.
REQ-034 Push 0x00..0x0F back-to-back with out_rdy=0 -> count=16, almost_full=1 once count reaches 12, and bytes pop in order 0x00..0x0F.
REQ-035 Full FIFO, push 0xAA with out_rdy=0 -> ovf=1, count=16, 0xAA absent; with the macro defined, ovf_cnt=1.
REQ-036 Full FIFO, push 0x55 with out_rdy=1 in the same cycle -> count stays 16, 0x55 becomes the last byte popped, ovf=0.
REQ-037 Push 20 bytes while popping each byte 2 cycles later -> pointers wrap, no drop, and the output sequence equals the input sequence.
REQ-038 Assert rst_n=0 with count=5 and ovf=1 -> count=0, out_vld=0 and ovf=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between a serial receiver and its consumer.
// Optional saturating dropped-byte counter is enabled by defining RX_BYTE_FIFO_OVF_CNT_EN.
module rx_byte_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_LEVEL   = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   input  logic [7:0]            in_data,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [7:0]            out_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  almost_full,
   output logic                  ovf,
   input  logic                  ovf_clr,
   output logic [7:0]            ovf_cnt
);

   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0]         CNT_AF   = CW'(AF_LEVEL);

   logic [7:0]            mem_q [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  almost_full_q, almost_full_d;
   logic                  ovf_q, ovf_d;
   logic                  full_s, pop_s, push_s, drop_s;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   always_comb begin
      full_s  = (count_q == CNT_FULL);
      pop_s   = (count_q != CNT_ZERO) && out_rdy;
      push_s  = in_vld && (!full_s || pop_s);
      drop_s  = in_vld && full_s && !pop_s;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      almost_full_d = (count_d >= CNT_AF);

      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q      <= PTR_ZERO;
         rd_ptr_q      <= PTR_ZERO;
         count_q       <= CNT_ZERO;
         almost_full_q <= 1'b0;
         ovf_q         <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         almost_full_q <= almost_full_d;
         ovf_q         <= ovf_d;
      end
   end

   // Byte storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

`ifdef RX_BYTE_FIFO_OVF_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   // Dropped-byte counter; a drop wins over a same-cycle clear.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop_s) begin
         ovf_cnt_d = sat_inc8(ovf_cnt_q);
      end else if (ovf_clr) begin
         ovf_cnt_d = 8'd0;
      end else begin
         ovf_cnt_d = ovf_cnt_q;
      end
   end

   // Dropped-byte counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= 8'd0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`else
   assign ovf_cnt = 8'd0;
`endif

   assign out_vld     = (count_q != CNT_ZERO);
   assign out_data    = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign almost_full = almost_full_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo: expected bytes are queued on push and
// compared on pop; flags come from a small reference model.
module tb_rx_byte_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_vld;
   logic [7:0] in_data;
   logic       out_vld;
   logic       out_rdy;
   logic [7:0] out_data;
   logic [4:0] count;
   logic       almost_full;
   logic       ovf;
   logic       ovf_clr;
   logic [7:0] ovf_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb_q[$];
   logic       exp_ovf;
   logic [7:0] exp_ovf_cnt;

   always #5 clk = ~clk;

   rx_byte_fifo #(.DEPTH_LOG2(4), .AF_LEVEL(12)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
      .count(count), .almost_full(almost_full), .ovf(ovf),
      .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_cnt_out();
`ifdef RX_BYTE_FIFO_OVF_CNT_EN
      return exp_ovf_cnt;
`else
      return 8'd0;
`endif
   endfunction

   // One clock cycle: check pre-edge outputs, update model, step, check flags.
   task automatic cycle(input logic vld, input logic [7:0] d, input logic rdy, input logic clr);
      logic pop, push, drop, full;
      in_vld = vld; in_data = d; out_rdy = rdy; ovf_clr = clr;
      #1;
      chk("out_vld", out_vld, sb_q.size() != 0);
      chk("count", count, sb_q.size());
      pop  = (sb_q.size() != 0) && rdy;
      full = (sb_q.size() == 16);
      drop = vld && full && !pop;
      push = vld && (!full || pop);
      if (pop) begin
         chk("out_data", out_data, sb_q[0]);
         void'(sb_q.pop_front());
      end
      if (push) sb_q.push_back(d);
      if (drop) begin
         exp_ovf = 1'b1;
         if (exp_ovf_cnt != 8'hFF) exp_ovf_cnt = exp_ovf_cnt + 8'd1;
      end else if (clr) begin
         exp_ovf = 1'b0;
         exp_ovf_cnt = 8'd0;
      end
      @(posedge clk);
      #1;
      chk("almost_full", almost_full, sb_q.size() >= 12);
      chk("ovf", ovf, exp_ovf);
      chk("ovf_cnt", ovf_cnt, exp_cnt_out());
      in_vld = 1'b0; out_rdy = 1'b0; ovf_clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b0; ovf_clr = 1'b0;
      exp_ovf = 1'b0; exp_ovf_cnt = 8'd0;
      #3;
      chk("rst_count", count, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single byte, held with out_rdy low, then consumed.
      cycle(1'b1, 8'h41, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill to full, then drops, drop-vs-clear priority, clear, push-on-pop at full.
      for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      cycle(1'b1, 8'hAB, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 8'h55, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Twenty bytes, each popped two cycles after it is pushed: pointers wrap.
      for (int i = 0; i < 24; i++)
         cycle(i < 20, 8'(8'h80 + i), i >= 2, 1'b0);

      // Random traffic with occasional clears.
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 4,
               $urandom_range(0, 19) == 0);
      for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Reach count=5 with ovf=1, then reset asynchronously mid-cycle.
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_count", count, 5);
      chk("pre_rst_ovf", ovf, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_out_vld", out_vld, 0);
      chk("async_rst_ovf", ovf, 0);
      chk("async_rst_ovf_cnt", ovf_cnt, 0);
      sb_q.delete();
      exp_ovf = 1'b0; exp_ovf_cnt = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
